router_pkt_tx: RTL and testbench
================================

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 Parameter GAP_CYCLES, default 3, idle cycles with pkt_valid low between packets (1..15).
REQ-002 clock  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ld_valid  input  1  host offers payload byte; ld_data  input  8  the byte.
REQ-005 ld_ready  output  1  byte accepted when ld_valid && ld_ready.
REQ-006 start  input  1  request to send loaded payload; dest  input  2  destination port 0..2.
REQ-007 tx_ready  output  1  high in IDLE with ld_cnt >= 1.
REQ-008 pkt_valid  output  1  to router pkt_valid; data_out  output  8  to router data_in.
REQ-009 busy  input  1  router busy; byte on data_out is taken on an edge where busy==0.
REQ-010 done  output  1  one-cycle pulse when the parity byte is taken.
REQ-011 rej  output  1  one-cycle pulse when start is rejected.

Function
REQ-012 States IDLE, HEADER, PAYLOAD, PARITY, GAP; data_out, pkt_valid, done and rej SHALL be registered.
REQ-013 IDLE: ld_ready = IDLE && ld_cnt < 63 && !start; each accepted byte is written to buffer[ld_cnt], ld_cnt increments.
REQ-014 IDLE, start && dest != 3 && ld_cnt >= 1: latch len = ld_cnt, header = {len[5:0], dest}, parity = header; go HEADER; header on data_out with pkt_valid=1 the next cycle.
REQ-015 IDLE, start && (dest == 3 || ld_cnt == 0): rej pulses next cycle, state, buffer and ld_cnt unchanged.
REQ-016 HEADER: hold header and pkt_valid=1 while busy; on busy==0 go PAYLOAD with rd_ptr = 0.
REQ-017 PAYLOAD: data_out = buffer[rd_ptr], pkt_valid=1; on busy==0, parity ^= byte and rd_ptr++; after byte len-1 is taken, go PARITY.
REQ-018 Any busy-high cycle SHALL hold data_out and pkt_valid unchanged; pkt_valid never drops before the last payload byte is taken.
REQ-019 PARITY: pkt_valid=0, data_out = parity; hold while busy; on busy==0, done pulses, ld_cnt clears, go GAP.
REQ-020 GAP: pkt_valid=0, data_out=0 for GAP_CYCLES cycles, then IDLE.
REQ-021 Header appears one cycle after accepted start; with busy low throughout, a packet occupies exactly len+2 cycles on data_out.
REQ-022 len is 6 bits; ld_cnt saturates at 63; bytes offered at 63 are not accepted.

Reset
REQ-023 reset SHALL force state IDLE, pkt_valid=0, data_out=0, done=0, rej=0, ld_cnt=0, rd_ptr=0, parity=0.
REQ-024 reset mid-packet SHALL abort the packet: pkt_valid is 0 from the cycle after reset, and no done pulse.
REQ-025 Buffer contents need no reset.

Configuration
REQ-026 Macro ROUTER_PKT_TX_PARITY_INJ_EN: when defined, an input inj_parity_err (1 bit) is sampled with an accepted start, and the sent parity byte is bit-inverted for that packet.
REQ-027 When the macro is undefined, port inj_parity_err is absent and the parity byte is always correct.

Structure
REQ-028 Shared package router_pkg: state encoding, MAX_LEN = 63, DEST_INVALID = 2'b11, header field widths.
REQ-029 One sub-module router_tx_buf: 64x8 single-write, single-read payload buffer with registered read; its latency is absorbed by prefetching rd_ptr in HEADER.

Verification
REQ-030 Load 0x11,0x22,0x33, start dest=1, busy=0 -> data_out 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0, done pulse.
REQ-031 Same packet, busy high 2 cycles while 0x22 is on data_out -> 0x22 and pkt_valid=1 held 3 cycles, parity still 0x0D.
REQ-032 start with dest=3, or with no bytes loaded -> rej pulse, pkt_valid stays 0, ld_cnt unchanged.
REQ-033 Offer 64 bytes 0x00..0x3F, start dest=2 -> ld_ready low after 63 bytes, header 0xFE, 63 payload bytes 0x00..0x3E.
REQ-034 reset asserted during payload byte 2 of 5 -> pkt_valid=0 next cycle, no done, tx_ready=0 until new load.
REQ-035 With ROUTER_PKT_TX_PARITY_INJ_EN, inj_parity_err=1 on REQ-030 stimulus -> parity byte 0xF2.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
// State encoding, header field widths and the header packing helper.
package router_pkg;

    localparam int DATA_W    = 8;
    localparam int LEN_W     = 6;
    localparam int DEST_W    = 2;
    localparam int BUF_DEPTH = 1 << LEN_W;
    localparam int MAX_LEN   = 63;

    localparam logic [DEST_W-1:0] DEST_INVALID = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } tx_state_e;

    function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                      input logic [DEST_W-1:0] dest);
        return {len, dest};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// 64x8 payload buffer: one write port, one read port with a registered read.
// Read-during-write to the same address returns the previous contents.
module router_tx_buf
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              wr_en,
    input  logic [LEN_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LEN_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [BUF_DEPTH];

    // NOTE: the array is not reset; it always holds bytes written before they are read, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding a router: loads a payload, then sends header, payload and parity.
// Optional macro ROUTER_PKT_TX_PARITY_INJ_EN adds inj_parity_err to corrupt one packet's parity byte.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int GAP_CYCLES = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              start,
    input  logic [DEST_W-1:0] dest,
    output logic              tx_ready,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    input  logic              busy,
    output logic              done,
    output logic              rej
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
    ,
    input  logic              inj_parity_err
`endif
);

    localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [LEN_W-1:0] CNT_FULL = LEN_W'(MAX_LEN);

    tx_state_e         state, state_nx;
    logic [LEN_W-1:0]  ld_cnt, ld_cnt_nx;
    logic [LEN_W-1:0]  len, len_nx;
    logic [LEN_W-1:0]  rd_ptr, rd_ptr_nx;
    logic [DATA_W-1:0] parity, parity_nx;
    logic [3:0]        gap_cnt, gap_cnt_nx;
    logic [DATA_W-1:0] data_out_nx;
    logic              pkt_valid_nx, done_nx, rej_nx;

    logic              wr_en;
    logic [LEN_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              start_ok;
    logic [DATA_W-1:0] inj_mask;
    logic [DATA_W-1:0] header;

    assign ld_ready = (state == ST_IDLE) && (ld_cnt != CNT_FULL) && !start;
    assign tx_ready = (state == ST_IDLE) && (ld_cnt != '0);
    assign wr_en    = ld_valid && ld_ready;
    assign start_ok = (state == ST_IDLE) && start && (dest != DEST_INVALID) && (ld_cnt != '0);
    assign header   = make_header(ld_cnt, dest);

`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
    logic inj_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            inj_q <= 1'b0;
        end else if (start_ok) begin
            inj_q <= inj_parity_err;
        end
    end

    assign inj_mask = {DATA_W{inj_q}};
`else
    assign inj_mask = '0;
`endif

    router_tx_buf u_buf (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (ld_cnt),
        .wr_data (ld_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx     = state;
        ld_cnt_nx    = ld_cnt;
        len_nx       = len;
        rd_ptr_nx    = rd_ptr;
        parity_nx    = parity;
        gap_cnt_nx   = gap_cnt;
        data_out_nx  = data_out;
        pkt_valid_nx = pkt_valid;
        done_nx      = 1'b0;
        rej_nx       = 1'b0;
        rd_addr      = '0;

        case (state)
            ST_IDLE: begin
                if (wr_en) begin
                    ld_cnt_nx = ld_cnt + LEN_W'(1);
                end
                if (start_ok) begin
                    len_nx       = ld_cnt;
                    parity_nx    = header;
                    data_out_nx  = header;
                    pkt_valid_nx = 1'b1;
                    rd_ptr_nx    = '0;
                    state_nx     = ST_HEADER;
                end else if (start) begin
                    rej_nx = 1'b1;
                end
            end

            // rd_data always holds the byte that goes out after the one on data_out.
            ST_HEADER: begin
                rd_addr = busy ? LEN_W'(0) : LEN_W'(1);
                if (!busy) begin
                    data_out_nx = rd_data;
                    rd_ptr_nx   = '0;
                    state_nx    = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                rd_addr = busy ? rd_ptr + LEN_W'(1) : rd_ptr + LEN_W'(2);
                if (!busy) begin
                    parity_nx = parity ^ data_out;
                    if (rd_ptr == len - LEN_W'(1)) begin
                        data_out_nx  = parity_nx ^ inj_mask;
                        pkt_valid_nx = 1'b0;
                        state_nx     = ST_PARITY;
                    end else begin
                        data_out_nx = rd_data;
                        rd_ptr_nx   = rd_ptr + LEN_W'(1);
                    end
                end
            end

            ST_PARITY: begin
                if (!busy) begin
                    done_nx     = 1'b1;
                    ld_cnt_nx   = '0;
                    data_out_nx = '0;
                    gap_cnt_nx  = '0;
                    state_nx    = ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx = ST_IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt + 4'd1;
                end
            end

            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            ld_cnt    <= '0;
            len       <= '0;
            rd_ptr    <= '0;
            parity    <= '0;
            gap_cnt   <= '0;
            data_out  <= '0;
            pkt_valid <= 1'b0;
            done      <= 1'b0;
            rej       <= 1'b0;
        end else begin
            state     <= state_nx;
            ld_cnt    <= ld_cnt_nx;
            len       <= len_nx;
            rd_ptr    <= rd_ptr_nx;
            parity    <= parity_nx;
            gap_cnt   <= gap_cnt_nx;
            data_out  <= data_out_nx;
            pkt_valid <= pkt_valid_nx;
            done      <= done_nx;
            rej       <= rej_nx;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed and randomized packets against a byte-stream model.
// Define ROUTER_PKT_TX_PARITY_INJ_EN for both bench and RTL to exercise parity injection.
module tb_router_pkt_tx;

    localparam int GAP = 3;

    logic       clock;
    logic       reset;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       start;
    logic [1:0] dest;
    logic       tx_ready;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic       rej;
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
    logic       inj_parity_err;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;
    logic [7:0] pl_q[$];

    router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
        .clock     (clock),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .start     (start),
        .dest      (dest),
        .tx_ready  (tx_ready),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .rej       (rej)
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
        ,
        .inj_parity_err (inj_parity_err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Loads pl_q into an empty buffer, expecting each byte to be accepted.
    task automatic load_payload();
        for (int i = 0; i < pl_q.size(); i++) begin
            ld_valid = 1'b1;
            ld_data  = pl_q[i];
            #1;
            check_cnt++;
            if (ld_ready !== 1'b1) $display("FAIL load_ready byte=%0d got=%b exp=1", i, ld_ready);
            else pass_cnt++;
            cycle();
        end
        ld_valid = 1'b0;
        ld_data  = '0;
        check_cnt++;
        if (tx_ready !== (pl_q.size() > 0)) $display("FAIL tx_ready_after_load got=%b exp=%b", tx_ready, pl_q.size() > 0);
        else pass_cnt++;
    endtask

    // Starts a packet with the loaded pl_q and follows it byte by byte through the gap.
    task automatic send_packet(input logic [1:0] d, input int busy_pct,
                               input int stall_at, input int stall_len, input string tag);
        logic [7:0] exp_q[$];
        logic [7:0] par;
        logic       b;
        logic       exp_v;
        int         len, k, stalls, cyc;
        len = pl_q.size();
        par = 8'(((len & 63) << 2) | int'(d));
        exp_q.push_back(par);
        foreach (pl_q[i]) begin
            exp_q.push_back(pl_q[i]);
            par = par ^ pl_q[i];
        end
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
        if (inj_parity_err) par = ~par;
`endif
        exp_q.push_back(par);

        start = 1'b1;
        dest  = d;
        busy  = 1'b0;
        cycle();
        start = 1'b0;
        dest  = 2'd0;
        k = 0; stalls = 0; cyc = 0;
        while (k < len + 2 && cyc < 1000) begin
            exp_v = (k <= len);
            check_cnt++;
            if ({pkt_valid, done, data_out} !== {exp_v, 1'b0, exp_q[k]})
                $display("FAIL %s byte=%0d got v=%b done=%b data=%02h exp v=%b done=0 data=%02h",
                         tag, k, pkt_valid, done, data_out, exp_v, exp_q[k]);
            else pass_cnt++;
            if (k == stall_at && stalls < stall_len) begin
                b = 1'b1;
                stalls++;
            end else begin
                b = ($urandom_range(99) < busy_pct);
            end
            busy = b;
            cycle();
            cyc++;
            if (!b) k++;
        end
        busy = 1'b0;
        check_cnt++;
        if (k != len + 2) $display("FAIL %s timeout got bytes=%0d exp=%0d", tag, k, len + 2);
        else pass_cnt++;

        check_cnt++;
        if ({done, pkt_valid, data_out} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL %s done_pulse got done=%b v=%b data=%02h exp done=1 v=0 data=00", tag, done, pkt_valid, data_out);
        else pass_cnt++;
        for (int g = 1; g < GAP; g++) begin
            cycle();
            check_cnt++;
            if ({done, pkt_valid, ld_ready, data_out} !== {3'b000, 8'h00})
                $display("FAIL %s gap=%0d got done=%b v=%b ld_ready=%b data=%02h exp all 0", tag, g, done, pkt_valid, ld_ready, data_out);
            else pass_cnt++;
        end
        cycle();
        check_cnt++;
        if ({ld_ready, tx_ready} !== 2'b10)
            $display("FAIL %s idle_after_gap got ld_ready=%b tx_ready=%b exp 1 0", tag, ld_ready, tx_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        check_cnt++;
        if ({pkt_valid, done, rej, tx_ready, data_out} !== {4'b0000, 8'h00})
            $display("FAIL reset_outputs got v=%b done=%b rej=%b tx_ready=%b data=%02h exp all 0",
                     pkt_valid, done, rej, tx_ready, data_out);
        else pass_cnt++;
        reset = 1'b0;
        cycle();
        check_cnt++;
        if (ld_ready !== 1'b1) $display("FAIL reset_ld_ready got=%b exp=1", ld_ready);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        pl_q = '{8'h11, 8'h22, 8'h33};
        load_payload();
        send_packet(2'd1, 0, -1, 0, "basic");
    endtask

    task automatic test_busy_hold();
        pl_q = '{8'h11, 8'h22, 8'h33};
        load_payload();
        send_packet(2'd1, 0, 2, 2, "busy_hold");
    endtask

    task automatic test_reject();
        start = 1'b1;
        dest  = 2'd0;
        cycle();
        start = 1'b0;
        check_cnt++;
        if ({rej, pkt_valid} !== 2'b10) $display("FAIL rej_empty got rej=%b v=%b exp 1 0", rej, pkt_valid);
        else pass_cnt++;
        cycle();
        check_cnt++;
        if ({rej, tx_ready} !== 2'b00) $display("FAIL rej_empty_after got rej=%b tx_ready=%b exp 0 0", rej, tx_ready);
        else pass_cnt++;

        pl_q = '{8'hA5, 8'h3C};
        load_payload();
        start = 1'b1;
        dest  = 2'd3;
        cycle();
        start = 1'b0;
        dest  = 2'd0;
        check_cnt++;
        if ({rej, pkt_valid} !== 2'b10) $display("FAIL rej_dest3 got rej=%b v=%b exp 1 0", rej, pkt_valid);
        else pass_cnt++;
        cycle();
        check_cnt++;
        if ({rej, pkt_valid, tx_ready} !== 3'b001) $display("FAIL rej_dest3_after got rej=%b v=%b tx_ready=%b exp 0 0 1", rej, pkt_valid, tx_ready);
        else pass_cnt++;
        send_packet(2'd2, 0, -1, 0, "after_rej");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 64; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'(i);
            #1;
            check_cnt++;
            if (ld_ready !== (i < 63)) $display("FAIL sat_ld_ready byte=%0d got=%b exp=%b", i, ld_ready, i < 63);
            else pass_cnt++;
            cycle();
        end
        ld_valid = 1'b0;
        pl_q.delete();
        for (int i = 0; i < 63; i++) pl_q.push_back(8'(i));
        send_packet(2'd2, 0, -1, 0, "saturate");
    endtask

    task automatic test_reset_mid();
        pl_q.delete();
        for (int i = 0; i < 5; i++) pl_q.push_back(8'($urandom));
        load_payload();
        start = 1'b1;
        dest  = 2'd0;
        busy  = 1'b0;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        cycle();
        check_cnt++;
        if ({pkt_valid, data_out} !== {1'b1, pl_q[2]}) $display("FAIL mid_byte2 got v=%b data=%02h exp v=1 data=%02h", pkt_valid, data_out, pl_q[2]);
        else pass_cnt++;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_cnt++;
        if ({pkt_valid, done, data_out} !== {2'b00, 8'h00}) $display("FAIL mid_reset got v=%b done=%b data=%02h exp 0 0 00", pkt_valid, done, data_out);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check_cnt++;
            if ({pkt_valid, done, tx_ready} !== 3'b000) $display("FAIL mid_after cyc=%0d got v=%b done=%b tx_ready=%b exp 0 0 0", i, pkt_valid, done, tx_ready);
            else pass_cnt++;
        end
        pl_q = '{8'h5A};
        load_payload();
        send_packet(2'd0, 0, -1, 0, "post_reset");
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            pl_q.delete();
            for (int i = 0; i < int'($urandom_range(20, 1)); i++) pl_q.push_back(8'($urandom));
            load_payload();
            send_packet(2'($urandom_range(2)), 35, -1, 0, "random");
        end
    endtask

`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
    task automatic test_parity_inj();
        pl_q = '{8'h11, 8'h22, 8'h33};
        load_payload();
        inj_parity_err = 1'b1;
        send_packet(2'd1, 0, -1, 0, "parity_inj");
        inj_parity_err = 1'b0;
        pl_q = '{8'h11, 8'h22, 8'h33};
        load_payload();
        send_packet(2'd1, 0, -1, 0, "parity_clean");
    endtask
`endif

    initial begin
        reset    = 1'b1;
        ld_valid = 1'b0;
        ld_data  = '0;
        start    = 1'b0;
        dest     = '0;
        busy     = 1'b0;
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
        inj_parity_err = 1'b0;
`endif
        test_reset();
        test_basic();
        test_busy_hold();
        test_reject();
        test_saturation();
        test_reset_mid();
        test_random();
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
        test_parity_inj();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
